// File: rtl/multi_sel_seq.sv
// multi_sel_seq: constant-coefficient sequential multiplier.
// Accepts one unsigned sample through a valid/ready handshake. It then emits
// sample*COEF[k] for k = 0..NCOEF-1 on consecutive cycles. Each product is
// built from shift-add terms of a fixed coefficient. Samples can be chained
// back to back with no bubble.
//
// Optional feature macro: MULTI_SEL_BP_EN adds the out_ready port (output backpressure).
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   d            input sample (DW bits)
//   in_valid     d is valid
//   in_ready     block can accept d this cycle (combinational)
//   input_grant  one-cycle pulse with the first product of a new sample
//   out          product d_reg*COEF[out_idx] (OW bits)
//   out_idx      coefficient index of out
//   out_valid    out/out_idx valid
//   out_ready    downstream accepts out (MULTI_SEL_BP_EN only)
module multi_sel_seq #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4,
  parameter int unsigned NCOEF = 4,
  parameter logic [NCOEF*CW-1:0] COEFS = 16'h8731,
  localparam int unsigned OW = DW + CW,
  localparam int unsigned IW = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          input_grant,
  output logic [OW-1:0] out,
  output logic [IW-1:0] out_idx,
`ifdef MULTI_SEL_BP_EN
  input  logic          out_ready,
`endif
  output logic          out_valid
);

`ifndef MULTI_SEL_BP_EN
  logic out_ready;
  assign out_ready = 1'b1;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] d_reg_q, d_reg_d;
  logic [OW-1:0] out_q, out_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          grant_q, grant_d;

  // The coefficient is a constant, so every set bit becomes one shifted addend.
  function automatic logic [OW-1:0] shift_add(input logic [DW-1:0] x, input logic [CW-1:0] c);
    logic [OW-1:0] acc;
    acc = '0;
    for (int b = 0; b < CW; b++) begin
      if (c[b]) acc = acc + (OW'(x) << b);
    end
    return acc;
  endfunction

  // One fixed-coefficient product per index from the held sample. Index 0 also
  // gets a product from the incoming sample so that a load can show it at once.
  logic [OW-1:0] prod_reg [NCOEF];
  logic [OW-1:0] prod_new0;

  for (genvar k = 0; k < NCOEF; k++) begin : g_prod
    assign prod_reg[k] = shift_add(d_reg_q, COEFS[k*CW +: CW]);
  end
  assign prod_new0 = shift_add(d, COEFS[CW-1:0]);

  logic          adv, last, accept;
  logic [IW-1:0] idx_nxt;

  assign adv      = valid_q & out_ready;
  assign last     = (idx_q == IW'(NCOEF - 1));
  assign in_ready = (state_q == StIdle) | (last & adv);
  assign accept   = in_valid & in_ready;
  assign idx_nxt  = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    d_reg_d = d_reg_q;
    out_d   = out_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    grant_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          d_reg_d = d;
          out_d   = prod_new0;
          idx_d   = '0;
          valid_d = 1'b1;
          grant_d = 1'b1;
        end
      end
      StRun: begin
        if (adv) begin
          if (!last) begin
            idx_d = idx_nxt;
            out_d = prod_reg[idx_nxt];
          end else if (accept) begin
            // Chain: the next sample's first product follows with no bubble.
            d_reg_d = d;
            out_d   = prod_new0;
            idx_d   = '0;
            grant_d = 1'b1;
          end else begin
            // out keeps the last product while idle.
            state_d = StIdle;
            valid_d = 1'b0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      d_reg_q <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_reg_q <= d_reg_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign out         = out_q;
  assign out_idx     = idx_q;
  assign out_valid   = valid_q;
  assign input_grant = grant_q;

endmodule

// File: tb/tb_multi_sel_seq.sv
// Testbench for multi_sel_seq.
// A queue-based reference model holds the products that are still owed. Each
// accepted sample pushes NCOEF (value, index, first) entries. An advance pops
// the head, and the head is what the DUT must be showing. The default
// instance gets directed and random traffic. A second, differently
// parameterised instance gets a short directed check.
module tb_multi_sel_seq;

  localparam int unsigned NC = 4;
  localparam logic [15:0] CF = 16'h8731;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  d;
  logic        in_valid;
  logic        in_ready;
  logic        input_grant;
  logic [11:0] out;
  logic [1:0]  out_idx;
  logic        out_valid;
  logic        out_ready;

  logic [3:0]  d2;
  logic        in_valid2;
  logic        in_ready2;
  logic        grant2;
  logic [6:0]  out2;
  logic [0:0]  idx2;
  logic        valid2;
  logic        out_ready2;

  always #5 clk = ~clk;

  multi_sel_seq dut (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_grant (input_grant),
    .out         (out),
    .out_idx     (out_idx),
`ifdef MULTI_SEL_BP_EN
    .out_ready   (out_ready),
`endif
    .out_valid   (out_valid)
  );

  multi_sel_seq #(
    .DW    (4),
    .CW    (3),
    .NCOEF (2),
    .COEFS (6'o75)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .d           (d2),
    .in_valid    (in_valid2),
    .in_ready    (in_ready2),
    .input_grant (grant2),
    .out         (out2),
    .out_idx     (idx2),
`ifdef MULTI_SEL_BP_EN
    .out_ready   (out_ready2),
`endif
    .out_valid   (valid2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct packed {
    logic [11:0] val;
    logic [1:0]  idx;
    logic        first;
  } item_t;

  item_t       q[$];
  logic [11:0] last_out = '0;
  bit          shown = 1'b0;

  function automatic int coef(input int k);
    logic [15:0] c;
    c = CF >> (k * 4);
    return int'(c[3:0]);
  endfunction

  // One clock cycle. The task drives the inputs at the negedge and checks the
  // outputs 1 time unit later. It then advances the model at the posedge.
  task automatic cyc(input bit r, input bit v, input logic [7:0] dv, input bit ordy);
    bit          eff_rdy, e_valid, e_ready, adv, popped, was_busy;
    logic [11:0] e_out;
    logic [1:0]  e_idx;
    bit          e_grant;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    d         = dv;
    out_ready = ordy;
`ifdef MULTI_SEL_BP_EN
    eff_rdy = ordy;
`else
    eff_rdy = 1'b1;
`endif
    #1;
    e_valid = (q.size() != 0);
    e_out   = e_valid ? q[0].val : last_out;
    e_idx   = e_valid ? q[0].idx : 2'd0;
    e_grant = e_valid && q[0].first && !shown;
    adv     = e_valid && eff_rdy;
    e_ready = (q.size() == 0) || (q.size() == 1 && adv);
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out", 32'(out), 32'(e_out));
    check("out_idx", 32'(out_idx), 32'(e_idx));
    check("input_grant", 32'(input_grant), 32'(e_grant));
    check("in_ready", 32'(in_ready), 32'(e_ready));
    @(posedge clk);
    if (r) begin
      q.delete();
      last_out = '0;
      shown    = 1'b0;
    end else begin
      was_busy = e_valid;
      popped   = 1'b0;
      if (adv) begin
        last_out = q[0].val;
        void'(q.pop_front());
        popped = 1'b1;
      end
      if (v && e_ready) begin
        for (int k = 0; k < NC; k++) begin
          q.push_back('{val: 12'(int'(dv) * coef(k)), idx: 2'(k), first: (k == 0)});
        end
      end
      shown = was_busy && !popped && (q.size() != 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    d          = '0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    d2         = '0;
    out_ready2 = 1'b1;
    repeat (2) @(posedge clk);

    // Second instance: coefficients 5 and 7, sample 15.
    @(negedge clk);
    rst       = 1'b0;
    in_valid2 = 1'b1;
    d2        = 4'd15;
    #1;
    check("p2_reset_valid", 32'(valid2), 32'd0);
    check("p2_reset_out", 32'(out2), 32'd0);
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    check("p2_out0", 32'(out2), 32'd75);
    check("p2_idx0", 32'(idx2), 32'd0);
    check("p2_grant0", 32'(grant2), 32'd1);
    @(negedge clk);
    #1;
    check("p2_out1", 32'(out2), 32'd105);
    check("p2_idx1", 32'(idx2), 32'd1);
    check("p2_grant1", 32'(grant2), 32'd0);
    @(negedge clk);
    #1;
    check("p2_done_valid", 32'(valid2), 32'd0);
    check("p2_hold_out", 32'(out2), 32'd105);

    // Single sample 10.
    cyc(1'b0, 1'b1, 8'd10, 1'b1);
    idle(6);
    // 255 followed by 1 held valid: chained with no bubble.
    cyc(1'b0, 1'b1, 8'd255, 1'b1);
    repeat (4) cyc(1'b0, 1'b1, 8'd1, 1'b1);
    idle(6);
    // Reset while idx1 is shown.
    cyc(1'b0, 1'b1, 8'd10, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    cyc(1'b1, 1'b0, 8'd0, 1'b1);
    idle(3);
    // Stall at idx2 (only effective with backpressure).
    cyc(1'b0, 1'b1, 8'd10, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 8'd0, 1'b0);
    idle(4);
    // Sample offered mid-sequence is ignored.
    cyc(1'b0, 1'b1, 8'd10, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 1'b1, 8'd99, 1'b1);
    idle(5);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
          8'($urandom), ($urandom_range(0, 3) != 0));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
